// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory path: access-size encodings, store-unit
// states and the size-to-byte-count helper.
package cpu_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StDone = 2'd2,
    StErr  = 2'd3
  } state_e;

  // Number of bytes moved for a given access size; 0 for the illegal encoding.
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      SZ_WORD: n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/store_narrow_unit_if.sv
// Bundles the CPU store request channel, the byte-wide memory write channel
// and the completion/status pulses of the store narrowing unit.
interface store_narrow_unit_if #(
  parameter int unsigned ADDR_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic [1:0]        req_size;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              done;
  logic              err;
  logic              trunc_ovf;

  // Environment side: the CPU issuing stores plus the memory accepting bytes.
  modport master (
    output req_valid, req_addr, req_data, req_size, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, done, err, trunc_ovf
  );

  // Store unit side.
  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, done, err, trunc_ovf
  );

endinterface

// File: rtl/trunc_check.sv
// Flags a value that does not survive narrowing to byte/halfword as a signed
// quantity: the inverse of sign extension. Purely combinational.
module trunc_check
  import cpu_mem_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  size,
  output logic        ovf
);

  // The low bits never influence representability.
  logic unused_low;
  assign unused_low = ^data[6:0];

  // Representable iff every discarded bit equals the new sign bit.
  always_comb begin
    ovf = 1'b0;
    case (size)
      SZ_BYTE: ovf = !((&data[31:7]) || !(|data[31:7]));
      SZ_HALF: ovf = !((&data[31:15]) || !(|data[31:15]));
      default: ovf = 1'b0;
    endcase
  end

endmodule

// File: rtl/store_narrow_unit.sv
// Store narrowing unit: accepts a 32-bit store request, rejects illegal or
// misaligned ones, and otherwise writes the narrowed value little-endian to a
// byte-wide memory port, reporting whether truncation lost significant bits.
module store_narrow_unit
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input logic          clk,
  input logic          rst_n,
  store_narrow_unit_if.slave bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [2:0]        cnt_q;
  logic [1:0]        idx_q;
  logic              ovf_q;

  logic accept, bad_req, xfer, last, ovf_now;

  trunc_check u_trunc_check (
    .data (bus.req_data),
    .size (bus.req_size),
    .ovf  (ovf_now)
  );

  // Request decode: handshake, alignment and size legality, byte progress.
  always_comb begin
    accept  = bus.req_valid && (state_q == StIdle);
    bad_req = (bus.req_size == SZ_ILL)
           || ((bus.req_size == SZ_HALF) && bus.req_addr[0])
           || ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
    xfer    = (state_q == StSend) && bus.mem_ready;
    last    = ({1'b0, idx_q} == (cnt_q - 3'd1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = bad_req ? StErr : StSend;
      StSend:  if (xfer && last) state_d = StDone;
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request capture at accept and byte index advance on each transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      addr_q <= bus.req_addr;
      data_q <= bus.req_data;
      cnt_q  <= byte_count(bus.req_size);
      idx_q  <= '0;
      ovf_q  <= ovf_now;
    end else if (xfer) begin
      idx_q  <= idx_q + 2'd1;
    end
  end

  // Outputs decode from registered state only, so reset clears them at once.
  always_comb begin
    bus.req_ready = (state_q == StIdle);
    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.done      = 1'b0;
    bus.err       = 1'b0;
    bus.trunc_ovf = 1'b0;
    case (state_q)
      StSend: begin
        bus.mem_valid = 1'b1;
        // Address wraps modulo 2^ADDR_W by construction.
        bus.mem_addr  = addr_q + ADDR_W'(idx_q);
        bus.mem_wdata = data_q[{idx_q, 3'b000} +: 8];
      end
      StDone: begin
        bus.done      = 1'b1;
        bus.trunc_ovf = ovf_q;
      end
      StErr:   bus.err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/store_narrow_unit.md
Name: store_narrow_unit

Overview:
- Store-path counterpart of the load-side sign extender: takes a 32-bit register value plus an access size, narrows it to byte/halfword/word, and writes it to the byte-wide data memory one byte at a time.
- Reports when the truncation lost information, meaning the value was not representable as a signed quantity of the target size.
- Sits between the CPU memory stage (valid/ready request) and the 8-bit data-memory write port (valid/ready).

Parameters:
- ADDR_W, 32, width of request and memory addresses.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  store request present.
- req_ready  output  1  unit can accept a request; high only in IDLE.
- req_addr  input  ADDR_W  byte address of the store.
- req_data  input  32  register value to store.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- mem_valid  output  1  byte write presented to memory.
- mem_ready  input  1  memory accepts the byte this cycle.
- mem_addr  output  ADDR_W  byte address of the current write.
- mem_wdata  output  8  byte being written.
- done  output  1  one-cycle pulse: store completed.
- err  output  1  one-cycle pulse: request rejected (misaligned or illegal size).
- trunc_ovf  output  1  valid only with done; 1 if narrowing lost significant bits.

Behaviour:
- Reset (async, rst_n=0): state IDLE. req_ready=1 once released; mem_valid=0, mem_addr=0, mem_wdata=0, done=0, err=0, trunc_ovf=0.
- Handshake:
  - Request accepted on the clock edge where req_valid && req_ready.
  - Memory byte transferred on the edge where mem_valid && mem_ready.
  - mem_valid, once raised, stays high with mem_addr/mem_wdata stable until accepted.
- States: IDLE, SEND, DONE, ERR.
- IDLE:
  - On accept, latch addr, data and size; set byte count N (1/2/4).
  - Alignment check: half needs addr[0]=0; word needs addr[1:0]=0.
  - Size 11 or misaligned -> ERR. Otherwise -> SEND with index k=0.
- SEND:
  - mem_valid=1, mem_addr=addr+k, mem_wdata=data[8k+7:8k] (little-endian).
  - On transfer, k increments. After byte N-1 transfers -> DONE.
  - mem_ready low stalls indefinitely with no timeout.
- DONE: done=1 for exactly one cycle; trunc_ovf driven; -> IDLE.
- ERR: err=1 for exactly one cycle; no memory traffic issued; -> IDLE.
- Overflow rule (computed at accept, registered):
  - byte: 1 if data[31:7] is not all-equal.
  - half: 1 if data[31:15] is not all-equal.
  - word: always 0.
- Latency with mem_ready tied high, request accepted at edge 0:
  - bytes on cycles 1..N;
  - done in cycle N+1;
  - req_ready high again in cycle N+2.
  - err appears in cycle 1; req_ready high in cycle 2.
- mem_addr arithmetic is modulo 2^ADDR_W; wrap-around is permitted and not an error.
- req_valid while not in IDLE is ignored: req_ready=0, nothing latched.
- Reset mid-SEND: mem_valid drops immediately (async). Partial bytes already written stay in memory. No done or err is issued.
- done, err and mem_valid are never high together.

Decomposition:
- Shared package, cpu_mem_pkg:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - state encoding constants;
  - byte-count function size->N.
- One natural sub-module: trunc_check (combinational; data + size -> ovf). It is the inverse check of sign extension and is reusable by the ALU's narrowing paths.

Test Plan:
- Word store: addr=0x100, data=0x11223344, size=10, mem_ready=1 -> bytes 44@0x100, 33@0x101, 22@0x102, 11@0x103 on cycles 1-4; done cycle 5; trunc_ovf=0.
- Halfword overflow: addr=0x202, data=0x00018000, size=01 -> bytes 00@0x202, 80@0x203; done with trunc_ovf=1. Repeat with data=0xFFFF8000 -> trunc_ovf=0.
- Byte store with stalls: addr=0x7, data=0xFFFFFF85, size=00, mem_ready low for 3 cycles -> mem_valid held with addr 0x7 / data 0x85 stable; done cycle after acceptance; trunc_ovf=0.
- Errors:
  - size=11 -> err pulse cycle 1, mem_valid never high, req_ready high cycle 2.
  - size=10 with addr=0x102 -> err.
  - size=01 with addr=0x3 -> err.
- Reset mid-op: word store accepted; drop rst_n after the 2nd byte transfers -> mem_valid 0 immediately, no done. After release, req_ready=1 and a new byte store completes normally.
- Busy and wrap: req_valid held during SEND -> second request not latched until req_ready. Word store at addr=0xFFFFFFFC -> last byte at 0xFFFFFFFF, no err.
